// File: rtl/pwm_multi_channel.sv
// pwm_multi_channel: NCH PWM channels on one shared timebase. The timebase advances on a
// prescaler clock-enable. Period, duty, mode, polarity and enables are shadowed and are
// only taken up at a cycle boundary while running.
//
// dir state | meaning
// DIR_UP    | counting up (center mode), or the only state used in edge mode
// DIR_DOWN  | center mode counting down toward the cycle boundary at 0
module pwm_multi_channel #(
  parameter int CW    = 16,
  parameter int NCH   = 4,
  parameter int PSC_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [PSC_W-1:0]  prescale,
  input  logic [CW-1:0]     period,
  input  logic [NCH*CW-1:0] duty,
  input  logic              center_align,
  input  logic [NCH-1:0]    polarity,
  input  logic [NCH-1:0]    ch_en,
  output logic [NCH-1:0]    pwm_out,
  output logic              cycle_start,
  output logic [CW-1:0]     count
);

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;

  localparam logic [CW-1:0]    CNT_ONE = CW'(1);
  localparam logic [PSC_W-1:0] PSC_ONE = PSC_W'(1);

  logic [PSC_W-1:0]  psc_q, psc_d, prescale_sh_q;
  logic [CW-1:0]     count_q, count_d, period_sh_q;
  dir_e              dir_q, dir_d;
  logic [NCH*CW-1:0] duty_sh_q;
  logic              center_sh_q;
  logic [NCH-1:0]    pol_sh_q, ch_en_sh_q;
  logic [NCH-1:0]    pwm_q, pwm_d;
  logic              cs_q, en_q;
  logic              tick, boundary;

  // Prescaler tick and the timebase value that the next tick would produce
  always_comb begin
    tick    = (psc_q == prescale_sh_q);
    psc_d   = tick ? '0 : psc_q + PSC_ONE;
    count_d = count_q;
    dir_d   = dir_q;
    if (period_sh_q <= CNT_ONE) begin
      // Degenerate period: the count sits at 0 and every tick is a boundary
      count_d = '0;
    end else if (!center_sh_q) begin
      count_d = (count_q >= period_sh_q - CNT_ONE) ? '0 : count_q + CNT_ONE;
    end else if (dir_q == DIR_UP) begin
      if (count_q >= period_sh_q - CNT_ONE) begin
        dir_d   = DIR_DOWN;
        count_d = count_q - CNT_ONE;
      end else begin
        count_d = count_q + CNT_ONE;
      end
    end else begin
      count_d = (count_q == '0) ? '0 : count_q - CNT_ONE;
    end
    boundary = tick && (count_d == '0);
  end

  // Per-channel compare of the current count against the shadowed duty
  always_comb begin
    pwm_d = pol_sh_q;
    for (int i = 0; i < NCH; i++) begin
      if (enable) begin
        pwm_d[i] = (ch_en_sh_q[i] & (count_q < duty_sh_q[i*CW +: CW])) ^ pol_sh_q[i];
      end
    end
  end

  // Timebase, direction, shadow registers and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      psc_q         <= '0;
      count_q       <= '0;
      dir_q         <= DIR_UP;
      prescale_sh_q <= '0;
      period_sh_q   <= '0;
      duty_sh_q     <= '0;
      center_sh_q   <= 1'b0;
      pol_sh_q      <= '0;
      ch_en_sh_q    <= '0;
      pwm_q         <= '0;
      cs_q          <= 1'b0;
      en_q          <= 1'b0;
    end else begin
      en_q  <= enable;
      pwm_q <= pwm_d;
      if (!enable) begin
        psc_q         <= '0;
        count_q       <= '0;
        dir_q         <= DIR_UP;
        cs_q          <= 1'b0;
        prescale_sh_q <= prescale;
        period_sh_q   <= period;
        duty_sh_q     <= duty;
        center_sh_q   <= center_align;
        pol_sh_q      <= polarity;
        ch_en_sh_q    <= ch_en;
      end else begin
        // A fresh enable also marks the start of a cycle
        cs_q  <= boundary | ~en_q;
        psc_q <= psc_d;
        if (tick) begin
          count_q <= count_d;
          dir_q   <= dir_d;
        end
        if (boundary) begin
          dir_q         <= DIR_UP;
          prescale_sh_q <= prescale;
          period_sh_q   <= period;
          duty_sh_q     <= duty;
          center_sh_q   <= center_align;
          pol_sh_q      <= polarity;
          ch_en_sh_q    <= ch_en;
        end
      end
    end
  end

  assign pwm_out     = pwm_q;
  assign cycle_start = cs_q;
  assign count       = count_q;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Bench for pwm_multi_channel: a cycle-position reference model checked every clock,
// directed scenarios with hand-computed expectations, then randomized configuration traffic.
module tb_pwm_multi_channel;
  localparam int CW = 16;
  localparam int NCH = 4;
  localparam int PSC_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic [PSC_W-1:0]  prescale;
  logic [CW-1:0]     period;
  logic [NCH*CW-1:0] duty;
  logic              center_align;
  logic [NCH-1:0]    polarity;
  logic [NCH-1:0]    ch_en;
  logic [NCH-1:0]    pwm_out;
  logic              cycle_start;
  logic [CW-1:0]     count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pwm_multi_channel #(.CW(CW), .NCH(NCH), .PSC_W(PSC_W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .prescale(prescale), .period(period),
    .duty(duty), .center_align(center_align), .polarity(polarity), .ch_en(ch_en),
    .pwm_out(pwm_out), .cycle_start(cycle_start), .count(count)
  );

  // Reference model: the timebase is a position within the current cycle; the count is
  // derived from that position with the triangle/sawtooth formula.
  int m_psc, m_p, m_center, m_pos, m_pscpos;
  int m_duty[NCH];
  bit m_pol[NCH];
  bit m_chen[NCH];
  bit m_prev_en;
  logic [NCH-1:0] exp_pwm;
  logic           exp_cs;
  int             exp_count;

  function automatic int cyc_len();
    if (m_p <= 1) return 1;
    return m_center ? (2 * m_p - 2) : m_p;
  endfunction

  function automatic int pos_to_count(input int pos);
    if (m_p <= 1) return 0;
    return (pos < m_p) ? pos : (2 * m_p - 2 - pos);
  endfunction

  task automatic model_load();
    m_psc = int'(prescale);
    m_p = int'(period);
    m_center = int'(center_align);
    for (int i = 0; i < NCH; i++) begin
      m_duty[i] = int'(duty[i*CW +: CW]);
      m_pol[i] = polarity[i];
      m_chen[i] = ch_en[i];
    end
  endtask

  task automatic model_reset();
    m_psc = 0; m_p = 0; m_center = 0; m_pos = 0; m_pscpos = 0; m_prev_en = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      m_duty[i] = 0; m_pol[i] = 1'b0; m_chen[i] = 1'b0;
    end
    exp_pwm = '0; exp_cs = 1'b0; exp_count = 0;
  endtask

  task automatic model_step();
    int cur;
    if (!reset) begin
      model_reset();
    end else begin
      cur = pos_to_count(m_pos);
      for (int i = 0; i < NCH; i++) begin
        if (enable) exp_pwm[i] = (m_chen[i] && (cur < m_duty[i])) ^ m_pol[i];
        else        exp_pwm[i] = m_pol[i];
      end
      if (!enable) begin
        model_load();
        m_pscpos = 0; m_pos = 0; exp_cs = 1'b0;
      end else begin
        exp_cs = !m_prev_en;
        if (m_pscpos == m_psc) begin
          m_pscpos = 0;
          m_pos = (m_pos + 1) % cyc_len();
          if (m_pos == 0) begin
            exp_cs = 1'b1;
            model_load();
          end
        end else begin
          m_pscpos++;
        end
      end
      m_prev_en = enable;
      exp_count = pos_to_count(m_pos);
    end
  endtask

  initial model_reset();

  // Every-cycle comparison against the model, sampled 1 time unit after the edge
  always @(posedge clk) begin
    model_step();
    #1;
    tests++;
    if (count !== CW'(exp_count) || pwm_out !== exp_pwm || cycle_start !== exp_cs) begin
      fails++;
      $display("FAIL model t=%0t: count=%0d pwm=%b cs=%b, required count=%0d pwm=%b cs=%b",
               $time, count, pwm_out, cycle_start, exp_count, exp_pwm, exp_cs);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic set_duty(input int ch, input int v);
    duty[ch*CW +: CW] = CW'(v);
  endtask

  task automatic wait_cs(input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (cycle_start === 1'b1) seen = 1'b1;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL %s: cycle_start not seen within 200 clks", name);
    end
  endtask

  task automatic restart(input int p, input int psc, input bit ctr);
    @(negedge clk);
    enable = 1'b0;
    period = CW'(p);
    prescale = PSC_W'(psc);
    center_align = ctr;
    repeat (2) @(negedge clk);
    enable = 1'b1;
    wait_cs("enable_rise_cs");
    wait_cs("first_boundary_cs");
  endtask

  int hi, hi1, lo1, hi2, hi3;
  int seq2[8] = '{0, 1, 2, 3, 4, 3, 2, 1};
  bit found;

  initial begin
    reset = 1'b0; enable = 1'b0; prescale = '0; period = '0; duty = '0;
    center_align = 1'b0; polarity = '0; ch_en = '0;
    repeat (3) @(negedge clk);
    check("reset_count", int'(count), 0);
    check("reset_pwm", int'(pwm_out), 0);
    check("reset_cs", int'(cycle_start), 0);
    reset = 1'b1;

    // 1: edge, prescale 0, P=10, duty 3
    set_duty(0, 3); ch_en = 4'b0001; polarity = '0;
    restart(10, 0, 1'b0);
    check("t1_count_at_cs", int'(count), 0);
    hi = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      hi += int'(pwm_out[0]);
      if (k < 10) check("t1_count_seq", int'(count), k);
    end
    check("t1_high_clks", hi, 3);
    check("t1_cs_period", int'(cycle_start), 1);

    // 2: center, P=5, duty 2
    set_duty(0, 2);
    restart(5, 0, 1'b1);
    hi = 0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        @(negedge clk);
        hi += int'(pwm_out[0]);
      end
      check("t2_count_seq", int'(count), seq2[k]);
    end
    @(negedge clk);
    hi += int'(pwm_out[0]);
    check("t2_high_ticks", hi, 3);
    check("t2_cs_period", int'(cycle_start), 1);

    // 3: prescale 2, edge, P=4, duty 1
    set_duty(0, 1);
    restart(4, 2, 1'b0);
    hi = 0;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) begin
        @(negedge clk);
        hi += int'(pwm_out[0]);
      end
      check("t3_count_hold", int'(count), k / 3);
    end
    @(negedge clk);
    hi += int'(pwm_out[0]);
    check("t3_high_clks", hi, 3);
    check("t3_cs_period", int'(cycle_start), 1);

    // 4: duty 3 -> 7 mid-cycle
    set_duty(0, 3);
    restart(10, 0, 1'b0);
    hi = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      hi += int'(pwm_out[0]);
      if (k == 4) set_duty(0, 7);
    end
    check("t4_old_duty_high", hi, 3);
    check("t4_cs", int'(cycle_start), 1);
    hi = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      hi += int'(pwm_out[0]);
    end
    check("t4_new_duty_high", hi, 7);

    // 5: 0% / 100% / inverted / disabled channels
    set_duty(0, 0); set_duty(1, 12); set_duty(2, 3); set_duty(3, 5);
    polarity = 4'b0100; ch_en = 4'b0111;
    restart(10, 0, 1'b0);
    hi = 0; hi1 = 0; lo1 = 0; hi2 = 0; hi3 = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      hi += int'(pwm_out[0]);
      lo1 += int'(!pwm_out[1]);
      hi2 += int'(pwm_out[2]);
      hi3 += int'(pwm_out[3]);
    end
    check("t5_duty0_high", hi, 0);
    check("t5_duty12_low", lo1, 0);
    check("t5_inverted_high", hi2, 21);
    check("t5_disabled_high", hi3, 0);

    // 6: reset mid-cycle, release with enable held high
    set_duty(0, 3); polarity = '0; ch_en = 4'b0001;
    restart(10, 0, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(negedge clk);
      if (count == CW'(5)) found = 1'b1;
    end
    check("t6_reach_count5", int'(found), 1);
    reset = 1'b0;
    #1;
    check("t6_rst_count", int'(count), 0);
    check("t6_rst_pwm", int'(pwm_out), 0);
    check("t6_rst_cs", int'(cycle_start), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t6_first_cs", int'(cycle_start), 1);
    check("t6_first_count", int'(count), 0);
    hi = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      hi += int'(pwm_out[0]);
      if (k < 10) check("t6_count_seq", int'(count), k);
    end
    check("t6_high_clks", hi, 3);
    check("t6_second_cs", int'(cycle_start), 1);

    // Randomized configuration traffic, checked by the model every clock
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      if (!reset) reset = 1'b1;
      else if ($urandom_range(0, 599) == 0) reset = 1'b0;
      if ($urandom_range(0, 59) == 0) enable = ~enable;
      if ($urandom_range(0, 19) == 0) period = CW'($urandom_range(0, 12));
      if ($urandom_range(0, 39) == 0) prescale = PSC_W'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) center_align = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) set_duty($urandom_range(0, NCH - 1), $urandom_range(0, 14));
      if ($urandom_range(0, 29) == 0) polarity = NCH'($urandom_range(0, 15));
      if ($urandom_range(0, 29) == 0) ch_en = NCH'($urandom_range(0, 15));
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
